fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter AW, default 8: program-counter / instruction-memory address width in bits.
REQ-002 Parameter IW, default 16: instruction width in bits.
REQ-003 Parameter RESET_PC, default 0: PC value loaded on reset (AW bits).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 stall  input  1  downstream not ready; hold the presented instruction.
REQ-007 branch_en  input  1  redirect fetch to branch_target this cycle.
REQ-008 branch_target  input  AW  redirect address; output of the PC-select 2:1 mux stage.
REQ-009 imem_req  output  1  instruction-memory read request.
REQ-010 imem_addr  output  AW  instruction-memory read address.
REQ-011 imem_ack  input  1  memory returns valid imem_data this cycle.
REQ-012 imem_data  input  IW  instruction word from memory.
REQ-013 instr  output  IW  registered instruction for decode.
REQ-014 instr_pc  output  AW  registered address of instr.
REQ-015 instr_valid  output  1  instr/instr_pc hold a valid fetched instruction.
REQ-016 pc_next  output  AW  pc+1 (mod 2^AW), fed to in_0 of the downstream PC-select mux.

Function
REQ-017 Internal AW-bit pc register and 3-state FSM: IDLE, FETCH, VALID.
REQ-018 imem_req SHALL be 1 exactly when state==FETCH and branch_en==0; imem_addr SHALL equal pc at all times.
REQ-019 instr_valid SHALL be 1 exactly when state==VALID (registered, no combinational path from inputs).
REQ-020 pc_next SHALL be combinational pc+1, wrapping from 2^AW-1 to 0, no carry out.
REQ-021 IDLE -> FETCH unconditionally on the next edge (one idle cycle after reset).
REQ-022 FETCH, imem_ack=0: stay in FETCH; pc, instr, instr_pc unchanged (unbounded wait, no timeout).
REQ-023 FETCH, imem_ack=1: instr<=imem_data, instr_pc<=pc, pc<=pc+1 (wrap), go to VALID; fetch latency from request = 1 cycle after ack.
REQ-024 VALID, stall=1: stay in VALID; instr, instr_pc, pc held.
REQ-025 VALID, stall=0: go to FETCH; one-cycle bubble between consecutive instructions is required behaviour.
REQ-026 branch_en=1 in any non-IDLE state SHALL take priority over stall and imem_ack: pc<=branch_target, go to FETCH, instr_valid deasserts next cycle; imem_data arriving that cycle is discarded.
REQ-027 branch_en in IDLE SHALL load pc<=branch_target and still go to FETCH.
REQ-028 Stall in FETCH or IDLE SHALL have no effect.
REQ-029 imem_ack outside FETCH SHALL be ignored.
REQ-030 instr and instr_pc SHALL retain their last values when instr_valid=0.

Reset
REQ-031 rst=1 at a clock edge SHALL set state=IDLE, pc=RESET_PC, instr=0, instr_pc=0, overriding all other inputs, including mid-fetch and mid-stall.
REQ-032 During and one cycle after reset: imem_req=0, instr_valid=0, imem_addr=RESET_PC, pc_next=RESET_PC+1.

Verification
REQ-033 Reset then ack on first FETCH cycle with imem_data=16'hA5A5 -> imem_req high at cycle 2, instr=16'hA5A5, instr_pc=0, instr_valid=1, pc=1 the next cycle.
REQ-034 Ack delayed 3 cycles in FETCH -> imem_req held 4 cycles, imem_addr constant, single VALID entry.
REQ-035 VALID with stall=1 for 5 cycles, then 0 -> instr/instr_pc stable for all 5, FETCH of next pc after release.
REQ-036 branch_en=1, branch_target=8'h40 while in VALID with stall=1 -> instr_valid=0 next cycle, imem_addr=8'h40, imem_req=1.
REQ-037 branch_en and imem_ack in the same FETCH cycle, imem_data=16'hDEAD -> data discarded, instr_valid stays 0, next request to branch_target.
REQ-038 pc=8'hFF, ack -> instr_pc=8'hFF, pc wraps to 0, pc_next=1; rst asserted mid-stall -> all outputs to reset values next edge.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Single-issue instruction fetch stage. Holds the program
//                counter, issues one instruction-memory read at a time and
//                presents the returned word, with its address, to decode.
//                A branch redirect takes priority over stall and memory ack.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_unit #(
    parameter int            AW       = 8,
    parameter int            IW       = 16,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          branch_en,
    input  logic [AW-1:0] branch_target,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [IW-1:0] imem_data,
    output logic [IW-1:0] instr,
    output logic [AW-1:0] instr_pc,
    output logic          instr_valid,
    output logic [AW-1:0] pc_next
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_fetch = 2'd1;
    localparam logic [1:0] c_st_valid = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [AW-1:0] r_pc;
    logic [IW-1:0] r_instr;
    logic [AW-1:0] r_instr_pc;
    logic [AW-1:0] w_pc_inc;
    logic          w_capture;

    // Incrementer wraps naturally at 2^AW; the carry is deliberately dropped.
    assign w_pc_inc  = r_pc + {{(AW-1){1'b0}}, 1'b1};
    // A redirect in the same cycle as an ack discards the returned word.
    assign w_capture = (r_state == c_st_fetch) && imem_ack && !branch_en;

    assign imem_addr = r_pc;
    assign pc_next   = w_pc_inc;
    assign instr     = r_instr;
    assign instr_pc  = r_instr_pc;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: a redirect always restarts fetch from the new pc.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                w_state_nxt = c_st_fetch;
            end
            c_st_fetch: begin
                if (branch_en) begin
                    w_state_nxt = c_st_fetch;
                end else if (imem_ack) begin
                    w_state_nxt = c_st_valid;
                end
            end
            c_st_valid: begin
                if (branch_en || !stall) begin
                    w_state_nxt = c_st_fetch;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Outputs decoded from state; instr_valid depends on the state register only.
    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (r_state)
            c_st_fetch: imem_req    = !branch_en;
            c_st_valid: instr_valid = 1'b1;
            default: begin
                imem_req    = 1'b0;
                instr_valid = 1'b0;
            end
        endcase
    end

    // Program counter: redirect from any state, otherwise advance on a captured word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (branch_en) begin
            r_pc <= branch_target;
        end else if (w_capture) begin
            r_pc <= w_pc_inc;
        end
    end

    // Instruction and its address are held until the next accepted fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr    <= '0;
            r_instr_pc <= '0;
        end else if (w_capture) begin
            r_instr    <= imem_data;
            r_instr_pc <= r_pc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit: directed scenarios plus
//                randomized traffic compared against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

    localparam int AW = 8;
    localparam int IW = 16;

    logic          clk;
    logic          rst;
    logic          stall;
    logic          branch_en;
    logic [AW-1:0] branch_target;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [IW-1:0] imem_data;
    logic [IW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;
    logic [AW-1:0] pc_next;

    int total = 0;
    int bad   = 0;

    fetch_unit #(.AW(AW), .IW(IW), .RESET_PC(8'h00)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_en    (branch_en),
        .branch_target(branch_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_data    (imem_data),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .pc_next      (pc_next)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: is the unit in its post-reset idle cycle, is an
    // instruction being presented, and what address comes next.
    bit      m_known = 0;
    bit      m_idle;
    bit      m_valid;
    int      m_pc;
    int      m_instr;
    int      m_ipc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: apply inputs, compare visible outputs against the
    // model, advance both across the edge, then return inputs to quiet.
    task automatic cycle(input bit r, input bit s, input bit b, input int tgt,
                         input bit a, input int d);
        rst = r; stall = s; branch_en = b; branch_target = AW'(tgt);
        imem_ack = a; imem_data = IW'(d);
        #2;
        if (m_known) begin
            check("req",   {31'd0, imem_req},    {31'd0, (!m_idle && !m_valid && !b)});
            check("addr",  {24'd0, imem_addr},   m_pc);
            check("pcnxt", {24'd0, pc_next},     (m_pc + 1) % 256);
            check("valid", {31'd0, instr_valid}, {31'd0, m_valid});
            check("instr", {16'd0, instr},       m_instr);
            check("ipc",   {24'd0, instr_pc},    m_ipc);
        end
        @(posedge clk);
        if (r) begin
            m_known = 1; m_idle = 1; m_valid = 0;
            m_pc = 0; m_instr = 0; m_ipc = 0;
        end else if (m_idle) begin
            m_idle = 0;
            if (b) m_pc = tgt;
        end else if (b) begin
            m_pc = tgt; m_valid = 0;
        end else if (m_valid) begin
            if (!s) m_valid = 0;
        end else if (a) begin
            m_instr = d; m_ipc = m_pc; m_pc = (m_pc + 1) % 256; m_valid = 1;
        end
        #1;
        rst = 0; stall = 0; branch_en = 0; branch_target = '0;
        imem_ack = 0; imem_data = '0;
        #1;
    endtask

    initial begin
        logic [IW-1:0] held_instr;
        logic [AW-1:0] held_ipc;
        rst = 1; stall = 0; branch_en = 0; branch_target = '0;
        imem_ack = 0; imem_data = '0;
        @(posedge clk); #1;

        // Reset, one idle cycle, then an immediate ack.
        cycle(1, 0, 0, 0, 0, 0);
        check("rst_req",   {31'd0, imem_req},    32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_addr",  {24'd0, imem_addr},   32'h00);
        check("rst_pcnxt", {24'd0, pc_next},     32'h01);
        cycle(0, 0, 0, 0, 0, 0);
        check("c2_req",    {31'd0, imem_req},    32'd1);
        cycle(0, 0, 0, 0, 1, 16'hA5A5);
        check("a5_instr",  {16'd0, instr},       32'hA5A5);
        check("a5_ipc",    {24'd0, instr_pc},    32'h00);
        check("a5_valid",  {31'd0, instr_valid}, 32'd1);
        check("a5_pc",     {24'd0, imem_addr},   32'h01);

        // Ack delayed three cycles.
        cycle(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            check("dly_req",  {31'd0, imem_req},  32'd1);
            check("dly_addr", {24'd0, imem_addr}, 32'h01);
            cycle(0, 0, 0, 0, 0, 0);
        end
        check("dly_req4", {31'd0, imem_req}, 32'd1);
        cycle(0, 0, 0, 0, 1, 16'h1234);
        check("dly_valid", {31'd0, instr_valid}, 32'd1);
        check("dly_ipc",   {24'd0, instr_pc},    32'h01);

        // Five stalled cycles, then release.
        held_instr = instr; held_ipc = instr_pc;
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 0, 0, 1, 16'hFFFF);
            check("stl_instr", {16'd0, instr},    {16'd0, held_instr});
            check("stl_ipc",   {24'd0, instr_pc}, {24'd0, held_ipc});
        end
        cycle(0, 0, 0, 0, 0, 0);
        check("rel_req",  {31'd0, imem_req},  32'd1);
        check("rel_addr", {24'd0, imem_addr}, 32'h02);

        // Branch while stalled in VALID.
        cycle(0, 0, 0, 0, 1, 16'h0202);
        cycle(0, 1, 1, 8'h40, 0, 0);
        check("br_valid", {31'd0, instr_valid}, 32'd0);
        check("br_addr",  {24'd0, imem_addr},   32'h40);
        check("br_req",   {31'd0, imem_req},    32'd1);

        // Branch and ack together: returned word is dropped.
        cycle(0, 0, 1, 8'h10, 1, 16'hDEAD);
        check("ba_valid", {31'd0, instr_valid}, 32'd0);
        check("ba_instr", {16'd0, instr},       32'h0202);
        check("ba_addr",  {24'd0, imem_addr},   32'h10);

        // Wrap at the top of the address space, then reset mid-stall.
        cycle(0, 0, 1, 8'hFF, 0, 0);
        cycle(0, 0, 0, 0, 1, 16'hBEEF);
        check("wr_ipc",   {24'd0, instr_pc}, 32'hFF);
        check("wr_addr",  {24'd0, imem_addr}, 32'h00);
        check("wr_pcnxt", {24'd0, pc_next},   32'h01);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 1, 16'h5555);
        check("rs_valid", {31'd0, instr_valid}, 32'd0);
        check("rs_instr", {16'd0, instr},       32'h0000);
        check("rs_ipc",   {24'd0, instr_pc},    32'h00);
        check("rs_addr",  {24'd0, imem_addr},   32'h00);
        check("rs_req",   {31'd0, imem_req},    32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 5) == 0),
                  int'($urandom_range(0, 255)),
                  ($urandom_range(0, 2) == 0),
                  int'($urandom_range(0, 65535)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
